// File: rtl/wb_master_arbiter.sv
// ============================================================================
// Module   : wb_master_arbiter
// Purpose  : Two-master, one-slave Wishbone arbiter. Round-robin grant held
//            for the owner's whole CYC. A watchdog ends hung transfers with ERR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic [ADDR_WIDTH-1:0] m0AdrI,
  input  logic [DATA_WIDTH-1:0] m0DatI,
  output logic [DATA_WIDTH-1:0] m0DatO,
  input  logic                  m0CycI,
  input  logic                  m0StbI,
  input  logic                  m0WeI,
  output logic                  m0AckO,
  output logic                  m0ErrO,
  // master 1
  input  logic [ADDR_WIDTH-1:0] m1AdrI,
  input  logic [DATA_WIDTH-1:0] m1DatI,
  output logic [DATA_WIDTH-1:0] m1DatO,
  input  logic                  m1CycI,
  input  logic                  m1StbI,
  input  logic                  m1WeI,
  output logic                  m1AckO,
  output logic                  m1ErrO,
  // slave
  output logic [ADDR_WIDTH-1:0] sAdrO,
  output logic [DATA_WIDTH-1:0] sDatO,
  input  logic [DATA_WIDTH-1:0] sDatI,
  output logic                  sCycO,
  output logic                  sStbO,
  output logic                  sWeO,
  input  logic                  sAckI,
  // one-hot owner, 00 = idle
  output logic [1:0]            gnt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            lastOwner_q, lastOwner_d;
  logic [WD_W-1:0] wdCnt_q, wdCnt_d;
  logic            errPend_q, errPend_d;

  logic own0, own1;
  logic ownCyc, ownStb;

  assign own0   = (state_q == OWN0);
  assign own1   = (state_q == OWN1);
  assign ownCyc = (own0 & m0CycI) | (own1 & m1CycI);
  assign ownStb = (own0 & m0StbI) | (own1 & m1StbI);

  // Next-state: arbitration, release and the watchdog counter.
  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
    wdCnt_d     = '0;
    errPend_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0CycI && m1CycI) begin
          // lastOwner_q == 1 means master 1 went last, so master 0 is next
          state_d = lastOwner_q ? OWN0 : OWN1;
        end else if (m0CycI) begin
          state_d = OWN0;
        end else if (m1CycI) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!ownCyc) begin
          // Release always passes through IDLE; a pending ERR is dropped.
          state_d     = IDLE;
          lastOwner_d = own1;
        end else if (errPend_q || sAckI || !ownStb) begin
          wdCnt_d = '0;
        end else if (wdCnt_q == WD_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th STB cycle with no ACK: flag ERR next.
          errPend_d = 1'b1;
        end else begin
          wdCnt_d = wdCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastOwner_q <= 1'b1;
      wdCnt_q     <= '0;
      errPend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
      wdCnt_q     <= wdCnt_d;
      errPend_q   <= errPend_d;
    end
  end

  // Slave mux and return path, purely combinational from the current owner.
  always_comb begin
    sAdrO  = '0;
    sDatO  = '0;
    sCycO  = 1'b0;
    sStbO  = 1'b0;
    sWeO   = 1'b0;
    m0DatO = '0;
    m0AckO = 1'b0;
    m0ErrO = 1'b0;
    m1DatO = '0;
    m1AckO = 1'b0;
    m1ErrO = 1'b0;
    gnt    = {own1, own0};
    if (own0) begin
      sAdrO  = m0AdrI;
      sDatO  = m0DatI;
      sCycO  = m0CycI;
      sStbO  = m0StbI & ~errPend_q;
      sWeO   = m0WeI;
      m0DatO = sDatI;
      m0AckO = sAckI & m0StbI;
      m0ErrO = errPend_q & m0CycI;
    end else if (own1) begin
      sAdrO  = m1AdrI;
      sDatO  = m1DatI;
      sCycO  = m1CycI;
      sStbO  = m1StbI & ~errPend_q;
      sWeO   = m1WeI;
      m1DatO = sDatI;
      m1AckO = sAckI & m1StbI;
      m1ErrO = errPend_q & m1CycI;
    end
  end

endmodule

`default_nettype wire
